// File: rtl/linebuffer_loader_if.sv
// Framebuffer read strobes and linebuffer write-side controls driven by the loader.
interface linebuffer_loader_if #(
  parameter int unsigned ADDRW = 20
) ();
  logic             fb_rd;
  logic [ADDRW-1:0] fb_addr;
  logic             lb_line;
  logic             lb_en;

  modport master (output fb_rd, output fb_addr, output lb_line, output lb_en);
  modport slave  (input  fb_rd, input  fb_addr, input  lb_line, input  lb_en);
endinterface

// File: rtl/linebuffer_loader.sv
// Fetches one framebuffer row per (scaled) display line into a linebuffer,
// timing the write enable to match the framebuffer read latency.
module linebuffer_loader #(
  parameter int unsigned LEN    = 640,
  parameter int unsigned LINES  = 480,
  parameter int unsigned SCALEW = 6,
  parameter int unsigned ADDRW  = 20,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic              frame,
  input  logic              line,
  input  logic [SCALEW-1:0] scale,
  input  logic [ADDRW-1:0]  fb_base,
  linebuffer_loader_if.master lb,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned CNTW = $clog2(LEN + RD_LAT + 1);
  localparam int unsigned ROWW = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_FETCH, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cyc, cyc_nxt;
  logic [ROWW-1:0]   row, row_nxt;
  logic [SCALEW-1:0] cnt_v, cnt_v_nxt;
  logic [SCALEW-1:0] scale_m1;
  logic [ADDRW-1:0]  line_addr, line_addr_nxt;
  logic              first, first_nxt;
  logic              overrun_nxt;
  logic              fetch_due;

  logic              busy_nxt, lb_line_nxt, fb_rd_nxt, lb_en_nxt;
  logic [ADDRW-1:0]  fb_addr_nxt;
  logic              lb_line_q, fb_rd_q, lb_en_q;
  logic [ADDRW-1:0]  fb_addr_q;

  // Scale 0 behaves as 1, so the wrap threshold never underflows.
  assign scale_m1 = (scale == '0) ? '0 : scale - SCALEW'(1);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state     <= S_IDLE;
      cyc       <= '0;
      row       <= '0;
      cnt_v     <= '0;
      line_addr <= '0;
      first     <= 1'b1;
      overrun   <= 1'b0;
      busy      <= 1'b0;
      lb_line_q <= 1'b0;
      fb_rd_q   <= 1'b0;
      fb_addr_q <= '0;
      lb_en_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cyc       <= cyc_nxt;
      row       <= row_nxt;
      cnt_v     <= cnt_v_nxt;
      line_addr <= line_addr_nxt;
      first     <= first_nxt;
      overrun   <= overrun_nxt;
      busy      <= busy_nxt;
      lb_line_q <= lb_line_nxt;
      fb_rd_q   <= fb_rd_nxt;
      fb_addr_q <= fb_addr_nxt;
      lb_en_q   <= lb_en_nxt;
    end
  end

  // Frame is applied before line, so a coincident line sees the freshly armed state.
  always_comb begin
    state_nxt     = state;
    cyc_nxt       = cyc;
    row_nxt       = row;
    cnt_v_nxt     = cnt_v;
    line_addr_nxt = line_addr;
    first_nxt     = first;
    overrun_nxt   = overrun;
    fetch_due     = 1'b0;

    if (frame) begin
      state_nxt     = S_IDLE;
      overrun_nxt   = 1'b0;
      first_nxt     = 1'b1;
      line_addr_nxt = fb_base;
      row_nxt       = '0;
      cnt_v_nxt     = '0;
    end

    if (line) begin
      if (state_nxt != S_IDLE) overrun_nxt = 1'b1;
      if (first_nxt) begin
        row_nxt   = '0;
        cnt_v_nxt = '0;
        first_nxt = 1'b0;
        fetch_due = 1'b1;
      end else if (cnt_v_nxt >= scale_m1) begin
        cnt_v_nxt = '0;
        if (row_nxt != ROWW'(LINES - 1)) begin
          row_nxt       = row_nxt + ROWW'(1);
          line_addr_nxt = line_addr_nxt + ADDRW'(LEN);
          fetch_due     = 1'b1;
        end
      end else begin
        cnt_v_nxt = cnt_v_nxt + SCALEW'(1);
      end
      state_nxt = fetch_due ? S_START : S_IDLE;
      cyc_nxt   = '0;
    end else if (!frame) begin
      // cyc counts busy cycles from START; FETCH covers 1..LEN, DRAIN LEN+1..LEN+RD_LAT.
      case (state)
        S_START: begin
          state_nxt = S_FETCH;
          cyc_nxt   = cyc + CNTW'(1);
        end
        S_FETCH: begin
          cyc_nxt = cyc + CNTW'(1);
          if (cyc == CNTW'(LEN)) state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          if (cyc == CNTW'(LEN + RD_LAT)) state_nxt = S_IDLE;
          else                            cyc_nxt   = cyc + CNTW'(1);
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered outputs decoded from the next state.
  always_comb begin
    busy_nxt    = (state_nxt != S_IDLE);
    lb_line_nxt = (state_nxt == S_START);
    fb_rd_nxt   = (state_nxt == S_FETCH);
    fb_addr_nxt = '0;
    if (fb_rd_nxt) fb_addr_nxt = line_addr_nxt + ADDRW'(cyc_nxt - CNTW'(1));
    lb_en_nxt   = busy_nxt && (cyc_nxt == CNTW'(RD_LAT));
  end

  assign lb.fb_rd   = fb_rd_q;
  assign lb.fb_addr = fb_addr_q;
  assign lb.lb_line = lb_line_q;
  assign lb.lb_en   = lb_en_q;

endmodule

// File: tb/tb_linebuffer_loader.sv
// Bench for linebuffer_loader: directed scenarios plus random line/frame traffic
// compared cycle by cycle against a row/offset reference model.
module tb_linebuffer_loader;

  localparam int unsigned LEN    = 8;
  localparam int unsigned LINES  = 4;
  localparam int unsigned SCALEW = 6;
  localparam int unsigned ADDRW  = 20;
  localparam int unsigned RD_LAT = 2;
  localparam int          WIN    = 1 + LEN + RD_LAT;

  logic              clk_sys = 1'b0;
  logic              rst_sys_n;
  logic              frame;
  logic              line;
  logic [SCALEW-1:0] scale;
  logic [ADDRW-1:0]  fb_base;
  logic              busy;
  logic              overrun;

  linebuffer_loader_if #(.ADDRW(ADDRW)) lb_if ();

  linebuffer_loader #(
    .LEN(LEN), .LINES(LINES), .SCALEW(SCALEW), .ADDRW(ADDRW), .RD_LAT(RD_LAT)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .frame     (frame),
    .line      (line),
    .scale     (scale),
    .fb_base   (fb_base),
    .lb        (lb_if),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_now = 0;

  // Reference model state
  bit               m_active;
  int               m_t0;
  logic [ADDRW-1:0] m_addr0;
  logic [ADDRW-1:0] m_base;
  int               m_row;
  int               m_cnt;
  bit               m_first;
  bit               m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_now, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_t0     = 0;
    m_addr0  = '0;
    m_base   = '0;
    m_row    = 0;
    m_cnt    = 0;
    m_first  = 1'b1;
    m_ovr    = 1'b0;
  endtask

  // Line/frame seen in cycle lc; a due fetch is scheduled relative to lc.
  task automatic model_step(input bit f, input bit l, input int lc);
    bit due;
    int sm1;
    due = 1'b0;
    if (f) begin
      m_active = 1'b0;
      m_ovr    = 1'b0;
      m_first  = 1'b1;
      m_base   = fb_base;
      m_row    = 0;
    end
    if (l) begin
      if (m_active && (lc - m_t0) >= 1 && (lc - m_t0) <= WIN) m_ovr = 1'b1;
      m_active = 1'b0;
      sm1 = (scale == 0) ? 0 : int'(scale) - 1;
      if (m_first) begin
        m_first = 1'b0;
        m_row   = 0;
        m_cnt   = 0;
        due     = 1'b1;
      end else if (m_cnt >= sm1) begin
        m_cnt = 0;
        if (m_row < int'(LINES) - 1) begin
          m_row = m_row + 1;
          due   = 1'b1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (due) begin
        m_active = 1'b1;
        m_t0     = lc;
        m_addr0  = ADDRW'(32'(m_base) + 32'(m_row) * 32'(LEN));
      end
    end
  endtask

  task automatic check_outputs();
    int k;
    logic [ADDRW-1:0] e_addr;
    bit e_rd;
    k = m_active ? (cyc_now - m_t0) : -1;
    e_rd   = (k >= 2) && (k <= 1 + int'(LEN));
    e_addr = e_rd ? m_addr0 + ADDRW'(k - 2) : '0;
    chk("busy",    32'(busy),          32'((k >= 1) && (k <= WIN)));
    chk("lb_line", 32'(lb_if.lb_line), 32'(k == 1));
    chk("fb_rd",   32'(lb_if.fb_rd),   32'(e_rd));
    chk("fb_addr", 32'(lb_if.fb_addr), 32'(e_addr));
    chk("lb_en",   32'(lb_if.lb_en),   32'(k == 1 + int'(RD_LAT)));
    chk("overrun", 32'(overrun),       32'(m_ovr));
  endtask

  task automatic tick(input bit f, input bit l);
    frame = f;
    line  = l;
    @(posedge clk_sys);
    cyc_now++;
    if (rst_sys_n) model_step(f, l, cyc_now - 1);
    #1;
    frame = 1'b0;
    line  = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  initial begin
    rst_sys_n = 1'b0;
    frame     = 1'b0;
    line      = 1'b0;
    scale     = SCALEW'(1);
    fb_base   = '0;
    model_reset();

    // Reset state
    #2;
    check_outputs();
    idle(2);
    rst_sys_n = 1'b1;
    idle(2);

    // Basic fetch from base 0x100
    fb_base = 20'h00100;
    tick(1'b1, 1'b0);
    idle(3);
    tick(1'b0, 1'b1);
    idle(14);

    // Scale 3: fetch on lines 1, 4, 7
    scale = SCALEW'(3);
    fb_base = 20'h00400;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b1);
      idle(19);
    end

    // Scale 1: six lines, last two past the final row
    scale = SCALEW'(1);
    fb_base = 20'h02000;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1);
      idle(19);
    end

    // Line during a fetch, then frame clears the sticky flag
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    idle(4);
    tick(1'b0, 1'b1);
    chk("overrun_set", 32'(overrun), 32'd1);
    idle(14);
    tick(1'b1, 1'b0);
    chk("overrun_clr", 32'(overrun), 32'd0);
    idle(2);

    // Frame and line together mid-fetch, new base, scale 0
    tick(1'b0, 1'b1);
    idle(5);
    fb_base = 20'hABCDE;
    scale   = '0;
    tick(1'b1, 1'b1);
    idle(13);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1);
      idle(13);
    end

    // Reset asserted mid-fetch
    scale = SCALEW'(2);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    idle(4);
    rst_sys_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    idle(2);
    rst_sys_n = 1'b1;
    fb_base = 20'h00055;
    tick(1'b1, 1'b1);
    idle(14);

    // Random traffic, including base near the address wrap
    for (int i = 0; i < 600; i++) begin
      bit f, l;
      f = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 7) == 0);
      if (f) begin
        fb_base = ($urandom_range(0, 1) == 0) ? 20'(32'hFFFE8 + $urandom_range(0, 23))
                                              : 20'($urandom);
        scale   = SCALEW'($urandom_range(0, 4));
      end else if ($urandom_range(0, 99) == 0) begin
        scale   = SCALEW'($urandom_range(0, 4));
      end
      tick(f, l);
    end
    idle(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
